// File: rtl/memo_core_if.sv
// Bus bundle for memo_core_top: lookup enable, GPR loader port and debug taps.
// Loader handshake: tb_init_valid is a single-cycle write strobe with no ready;
// the core accepts every strobed write at the next rising edge, and while the
// strobe is high the core performs no memo lookup that cycle.
interface memo_core_if;
  logic        memo_enable;
  logic        tb_init_valid;
  logic [4:0]  tb_init_idx;
  logic [31:0] tb_init_val;
  logic [31:0] dbg_pc;
  logic [31:0] dbg_hit_count;
  logic [31:0] dbg_miss_count;
  logic        dbg_state;      // 0 = LOOKUP, 1 = APPLY

  modport master (
    output memo_enable, tb_init_valid, tb_init_idx, tb_init_val,
    input  dbg_pc, dbg_hit_count, dbg_miss_count, dbg_state
  );

  modport slave (
    input  memo_enable, tb_init_valid, tb_init_idx, tb_init_val,
    output dbg_pc, dbg_hit_count, dbg_miss_count, dbg_state
  );
endinterface

// File: rtl/memo_core_top.sv
// Function-memoization core: PC + 32x32 GPR file + small preloaded memo table.
// Each idle cycle looks up (PC, ra+a0+a1); a hit writes the memoized return
// values into a0/a1 one cycle later and jumps PC to ra.

// GPR file. rf[0] is never written after reset so it always reads zero.
// Loader writes take priority over apply writes to the same register.
module memo_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tb_we_i,
  input  logic [4:0]  tb_idx_i,
  input  logic [31:0] tb_val_i,
  input  logic        wr_a0_i,
  input  logic [31:0] a0_val_i,
  input  logic        wr_a1_i,
  input  logic [31:0] a1_val_i,
  output logic [31:0] ra_o,
  output logic [31:0] a0_o,
  output logic [31:0] a1_o
);
  logic [31:0] rf [0:31];

  // Register writes: loader first, then apply writes to x10/x11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (tb_we_i && (tb_idx_i == 5'(i)))
          rf[i] <= tb_val_i;
        else if ((i == 10) && wr_a0_i)
          rf[i] <= a0_val_i;
        else if ((i == 11) && wr_a1_i)
          rf[i] <= a1_val_i;
      end
    end
  end

  assign ra_o = rf[1];
  assign a0_o = rf[10];
  assign a1_o = rf[11];
endmodule

module memo_core_top #(
  parameter int MEMO_ENTRIES = 4
) (
  input  logic         clk,
  input  logic         rst,      // asynchronous, active-low
  memo_core_if.slave   bus
);
  localparam int IDX_W = (MEMO_ENTRIES > 1) ? $clog2(MEMO_ENTRIES) : 1;

  typedef enum logic { ST_LOOKUP = 1'b0, ST_APPLY = 1'b1 } state_t;

  state_t      state_q, state_d;
  logic [31:0] PC;
  logic [31:0] pc_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Fields captured on a hit, consumed in APPLY.
  logic        lat_wr_a0_q, lat_wr_a0_d;
  logic        lat_wr_a1_q, lat_wr_a1_d;
  logic [31:0] lat_a0_q, lat_a0_d;
  logic [31:0] lat_a1_q, lat_a1_d;
  logic [31:0] lat_ra_q, lat_ra_d;

  // Memo table, reloaded with the demo entries on every reset.
  logic        tbl_valid_q [MEMO_ENTRIES];
  logic [31:0] tbl_pc_q    [MEMO_ENTRIES];
  logic [31:0] tbl_key_q   [MEMO_ENTRIES];
  logic        tbl_wr_a0_q [MEMO_ENTRIES];
  logic [31:0] tbl_a0_q    [MEMO_ENTRIES];
  logic        tbl_wr_a1_q [MEMO_ENTRIES];
  logic [31:0] tbl_a1_q    [MEMO_ENTRIES];

  logic [31:0] ra, a0, a1, key;
  logic        hit;
  logic [IDX_W-1:0] hit_idx;
  logic        apply_wr_a0, apply_wr_a1;

  memo_rf u_rf (
    .clk      (clk),
    .rst_n    (rst),
    .tb_we_i  (bus.tb_init_valid),
    .tb_idx_i (bus.tb_init_idx),
    .tb_val_i (bus.tb_init_val),
    .wr_a0_i  (apply_wr_a0),
    .a0_val_i (lat_a0_q),
    .wr_a1_i  (apply_wr_a1),
    .a1_val_i (lat_a1_q),
    .ra_o     (ra),
    .a0_o     (a0),
    .a1_o     (a1)
  );

  assign key = ra + a0 + a1;

  // Table contents: only reset loads them; they hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEMO_ENTRIES; i++) begin
        tbl_valid_q[i] <= 1'b0;
        tbl_pc_q[i]    <= '0;
        tbl_key_q[i]   <= '0;
        tbl_wr_a0_q[i] <= 1'b0;
        tbl_a0_q[i]    <= '0;
        tbl_wr_a1_q[i] <= 1'b0;
        tbl_a1_q[i]    <= '0;
      end
      tbl_valid_q[0] <= 1'b1;
      tbl_pc_q[0]    <= 32'h0000_1000;
      tbl_key_q[0]   <= 32'h0000_2005;
      tbl_wr_a0_q[0] <= 1'b1;
      tbl_a0_q[0]    <= 32'd12;
      tbl_valid_q[1] <= 1'b1;
      tbl_pc_q[1]    <= 32'h0000_3000;
      tbl_key_q[1]   <= 32'h0000_400C;
      tbl_wr_a0_q[1] <= 1'b1;
      tbl_a0_q[1]    <= 32'd42;
      tbl_wr_a1_q[1] <= 1'b1;
      tbl_a1_q[1]    <= 32'd77;
    end
  end

  // Fully associative match; scanning downward lets the lowest index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = MEMO_ENTRIES - 1; i >= 0; i--) begin
      if (tbl_valid_q[i] && (tbl_pc_q[i] == PC) && (tbl_key_q[i] == key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // FSM next state, counters, latches and apply strobes.
  always_comb begin
    state_d      = state_q;
    pc_d         = PC;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    lat_wr_a0_d  = lat_wr_a0_q;
    lat_wr_a1_d  = lat_wr_a1_q;
    lat_a0_d     = lat_a0_q;
    lat_a1_d     = lat_a1_q;
    lat_ra_d     = lat_ra_q;
    apply_wr_a0  = 1'b0;
    apply_wr_a1  = 1'b0;
    case (state_q)
      ST_LOOKUP: begin
        if (bus.memo_enable && !bus.tb_init_valid) begin
          if (hit) begin
            lat_wr_a0_d = tbl_wr_a0_q[hit_idx];
            lat_wr_a1_d = tbl_wr_a1_q[hit_idx];
            lat_a0_d    = tbl_a0_q[hit_idx];
            lat_a1_d    = tbl_a1_q[hit_idx];
            lat_ra_d    = ra;
            hit_count_d = hit_count_q + 32'd1;
            state_d     = ST_APPLY;
          end else begin
            miss_count_d = miss_count_q + 32'd1;
          end
        end
      end
      ST_APPLY: begin
        apply_wr_a0 = lat_wr_a0_q;
        apply_wr_a1 = lat_wr_a1_q;
        pc_d        = lat_ra_q;
        state_d     = ST_LOOKUP;
      end
      default: state_d = ST_LOOKUP;
    endcase
  end

  // State, PC, counters and hit latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_LOOKUP;
      PC           <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      lat_wr_a0_q  <= 1'b0;
      lat_wr_a1_q  <= 1'b0;
      lat_a0_q     <= '0;
      lat_a1_q     <= '0;
      lat_ra_q     <= '0;
    end else begin
      state_q      <= state_d;
      PC           <= pc_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      lat_wr_a0_q  <= lat_wr_a0_d;
      lat_wr_a1_q  <= lat_wr_a1_d;
      lat_a0_q     <= lat_a0_d;
      lat_a1_q     <= lat_a1_d;
      lat_ra_q     <= lat_ra_d;
    end
  end

  assign bus.dbg_pc         = PC;
  assign bus.dbg_hit_count  = hit_count_q;
  assign bus.dbg_miss_count = miss_count_q;
  assign bus.dbg_state      = (state_q == ST_APPLY);
endmodule

// File: tb/tb_memo_core_top.sv
// Directed bench for memo_core_top: reset, two hits, miss counting, disable,
// x0 write, lookup suppression, loader-vs-apply conflict, reset mid-apply.
module tb_memo_core_top;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  memo_core_if bus ();

  memo_core_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One loader write; called at a negedge, returns at the next negedge.
  task automatic write_gpr(input logic [4:0] idx, input logic [31:0] val);
    bus.tb_init_valid = 1'b1;
    bus.tb_init_idx   = idx;
    bus.tb_init_val   = val;
    @(negedge clk);
    bus.tb_init_valid = 1'b0;
  endtask

  // Places the core at a given PC with ra/a0/a1 loaded, lookups disabled.
  task automatic set_state(input logic [31:0] pc, input logic [31:0] ra_v,
                           input logic [31:0] a0_v, input logic [31:0] a1_v);
    bus.memo_enable = 1'b0;
    dut.PC = pc;
    write_gpr(5'd1, ra_v);
    write_gpr(5'd10, a0_v);
    write_gpr(5'd11, a1_v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.memo_enable   = 1'b0;
    bus.tb_init_valid = 1'b0;
    bus.tb_init_idx   = '0;
    bus.tb_init_val   = '0;

    // Reset held for 4 cycles
    tick(4);
    chk("rst_pc", bus.dbg_pc, 32'h0);
    chk("rst_hits", bus.dbg_hit_count, 32'h0);
    chk("rst_misses", bus.dbg_miss_count, 32'h0);
    chk("rst_state", {31'b0, bus.dbg_state}, 32'h0);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_rf%0d", i), dut.u_rf.rf[i], 32'h0);
    rst = 1'b1;
    tick(1);

    // Hit A: key 0x2000+5+0 = 0x2005 at PC 0x1000
    set_state(32'h1000, 32'h2000, 32'd5, 32'd0);
    bus.memo_enable = 1'b1;
    tick(1);
    chk("a_hits_edge1", bus.dbg_hit_count, 32'd1);
    chk("a_state_apply", {31'b0, bus.dbg_state}, 32'd1);
    chk("a_pc_edge1", bus.dbg_pc, 32'h1000);
    chk("a_a0_edge1", dut.u_rf.rf[10], 32'd5);
    bus.memo_enable = 1'b0;
    tick(1);
    chk("a_a0", dut.u_rf.rf[10], 32'd12);
    chk("a_a1", dut.u_rf.rf[11], 32'd0);
    chk("a_pc", bus.dbg_pc, 32'h2000);
    chk("a_hits", bus.dbg_hit_count, 32'd1);
    chk("a_misses", bus.dbg_miss_count, 32'd0);
    chk("a_state_lookup", {31'b0, bus.dbg_state}, 32'd0);

    // Hit B: key 0x4000+3+9 = 0x400C at PC 0x3000
    set_state(32'h3000, 32'h4000, 32'd3, 32'd9);
    bus.memo_enable = 1'b1;
    tick(1);
    bus.memo_enable = 1'b0;
    tick(1);
    chk("b_a0", dut.u_rf.rf[10], 32'd42);
    chk("b_a1", dut.u_rf.rf[11], 32'd77);
    chk("b_pc", bus.dbg_pc, 32'h4000);
    chk("b_hits", bus.dbg_hit_count, 32'd2);
    chk("b_misses", bus.dbg_miss_count, 32'd0);

    // Miss C: key 0x2006 matches nothing; 3 lookup cycles
    set_state(32'h1000, 32'h2000, 32'd6, 32'd0);
    bus.memo_enable = 1'b1;
    tick(3);
    bus.memo_enable = 1'b0;
    chk("c_misses", bus.dbg_miss_count, 32'd3);
    chk("c_hits", bus.dbg_hit_count, 32'd2);
    chk("c_pc", bus.dbg_pc, 32'h1000);
    chk("c_a0", dut.u_rf.rf[10], 32'd6);

    // Disabled with Hit-A state: nothing moves
    write_gpr(5'd10, 32'd5);
    tick(3);
    chk("d_pc", bus.dbg_pc, 32'h1000);
    chk("d_a0", dut.u_rf.rf[10], 32'd5);
    chk("d_hits", bus.dbg_hit_count, 32'd2);
    chk("d_misses", bus.dbg_miss_count, 32'd3);
    write_gpr(5'd0, 32'd5);
    chk("d_x0", dut.u_rf.rf[0], 32'd0);

    // Suppression: loader strobe held at a matching state
    bus.memo_enable   = 1'b1;
    bus.tb_init_valid = 1'b1;
    bus.tb_init_idx   = 5'd5;
    bus.tb_init_val   = 32'h55;
    tick(3);
    chk("s_hits_held", bus.dbg_hit_count, 32'd2);
    chk("s_misses_held", bus.dbg_miss_count, 32'd3);
    chk("s_pc_held", bus.dbg_pc, 32'h1000);
    chk("s_state_held", {31'b0, bus.dbg_state}, 32'd0);
    chk("s_x5", dut.u_rf.rf[5], 32'h55);
    bus.tb_init_valid = 1'b0;
    tick(1);
    chk("s_hits_after", bus.dbg_hit_count, 32'd3);
    chk("s_state_apply", {31'b0, bus.dbg_state}, 32'd1);
    bus.memo_enable = 1'b0;
    tick(1);
    chk("s_pc", bus.dbg_pc, 32'h2000);
    chk("s_a0", dut.u_rf.rf[10], 32'd12);
    chk("s_misses", bus.dbg_miss_count, 32'd3);

    // Loader write to a0 during APPLY wins; a1 still applied
    set_state(32'h3000, 32'h4000, 32'd3, 32'd9);
    bus.memo_enable = 1'b1;
    tick(1);
    bus.memo_enable = 1'b0;
    write_gpr(5'd10, 32'h99);
    chk("w_a0_tb_wins", dut.u_rf.rf[10], 32'h99);
    chk("w_a1", dut.u_rf.rf[11], 32'd77);
    chk("w_pc", bus.dbg_pc, 32'h4000);
    chk("w_hits", bus.dbg_hit_count, 32'd4);

    // Reset asserted while in APPLY aborts the apply
    set_state(32'h1000, 32'h2000, 32'd5, 32'd0);
    bus.memo_enable = 1'b1;
    tick(1);
    chk("r_state_apply", {31'b0, bus.dbg_state}, 32'd1);
    bus.memo_enable = 1'b0;
    rst = 1'b0;
    #1;
    chk("r_pc", bus.dbg_pc, 32'h0);
    chk("r_hits", bus.dbg_hit_count, 32'h0);
    chk("r_misses", bus.dbg_miss_count, 32'h0);
    chk("r_state", {31'b0, bus.dbg_state}, 32'd0);
    chk("r_ra", dut.u_rf.rf[1], 32'h0);
    tick(1);
    chk("r_a0_no_apply", dut.u_rf.rf[10], 32'h0);
    chk("r_pc_held", bus.dbg_pc, 32'h0);
    rst = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
